// File: rtl/digit_mode_ctrl.sv
// Mode controller and sequencer for a six-digit BCD time/timer datapath.
// Turns button pulses into registered step/set/clear strobes, keeps the
// 1 Hz prescaler, latches the count direction and drives the blink mask.
module digit_mode_ctrl #(
    parameter int CLK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       dir_sw,
    input  logic       cnt_zero,
    output logic       sec_step,
    output logic       min_step,
    output logic       hour_step,
    output logic       clear,
    output logic       count_down,
    output logic [5:0] blank,
    output logic       done,
    output logic [2:0] state
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_DIV / 2);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        PAUSE    = 3'd2,
        SET_HOUR = 3'd3,
        SET_MIN  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t        cur_state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic          cd_nxt, sec_nxt, min_nxt, hour_nxt, clr_nxt;
    logic [5:0]    blank_nxt;
    logic          tick, phase_nxt;
    logic          press_start, press_mode, press_inc;

    assign state = cur_state;
    assign tick  = (pre == PRE_LAST);

    // Button priority: start beats mode beats inc; losers are dropped.
    assign press_start = btn_start;
    assign press_mode  = btn_mode & ~btn_start;
    assign press_inc   = btn_inc & ~btn_start & ~btn_mode;

    // Next state, prescaler, direction, strobes and blank mask.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = cur_state;
        pre_nxt   = (cur_state == PAUSE) ? pre : (tick ? '0 : pre + 1'b1);
        cd_nxt    = count_down;
        sec_nxt   = 1'b0;
        min_nxt   = 1'b0;
        hour_nxt  = 1'b0;
        clr_nxt   = 1'b0;

        case (cur_state)
            IDLE: begin
                if (press_start) begin
                    cd_nxt = dir_sw;
                    // A countdown from 00:00:00 has nothing to do.
                    if (!(dir_sw && cnt_zero)) begin
                        state_nxt = RUN;
                        pre_nxt   = '0;
                    end
                end else if (press_mode) begin
                    state_nxt = SET_HOUR;
                end
            end
            RUN: begin
                if (press_start) begin
                    state_nxt = PAUSE;
                end else if (tick) begin
                    if (count_down && cnt_zero) state_nxt = DONE;
                    else                        sec_nxt   = 1'b1;
                end
            end
            PAUSE: begin
                if (press_start) begin
                    state_nxt = RUN;
                end else if (press_mode) begin
                    clr_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SET_HOUR: begin
                if (press_start)     state_nxt = IDLE;
                else if (press_mode) state_nxt = SET_MIN;
                else if (press_inc)  hour_nxt  = 1'b1;
            end
            SET_MIN: begin
                if (press_start || press_mode) state_nxt = IDLE;
                else if (press_inc)            min_nxt   = 1'b1;
            end
            DONE: begin
                if (press_start || press_mode || press_inc) begin
                    clr_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                // Unused codes recover to IDLE with everything quiet.
                state_nxt = IDLE;
                pre_nxt   = '0;
                cd_nxt    = 1'b0;
            end
        endcase

        // Blank mask follows the state and phase that will be current after the edge.
        phase_nxt = (pre_nxt >= PRE_HALF);
        case (state_nxt)
            SET_HOUR: blank_nxt = {2'b00, {2{phase_nxt}}, 2'b00};
            SET_MIN:  blank_nxt = {4'b0000, {2{phase_nxt}}};
            DONE:     blank_nxt = {6{phase_nxt}};
            default:  blank_nxt = 6'b000000;
        endcase
    end

    // State, prescaler and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state  <= IDLE;
            pre        <= '0;
            count_down <= 1'b0;
            sec_step   <= 1'b0;
            min_step   <= 1'b0;
            hour_step  <= 1'b0;
            clear      <= 1'b0;
            blank      <= 6'b000000;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cur_state  <= state_nxt;
            pre        <= pre_nxt;
            count_down <= cd_nxt;
            sec_step   <= sec_nxt;
            min_step   <= min_nxt;
            hour_step  <= hour_nxt;
            clear      <= clr_nxt;
            blank      <= blank_nxt;
            done       <= (state_nxt == DONE);
        end
    end

endmodule

// File: doc/digit_mode_ctrl.md
Name: digit_mode_ctrl

Overview:
Mode controller and sequencer for the six-digit BCD time/timer datapath (digits 1:0 minutes, 3:2 hours, 5:4 seconds).
- Takes debounced single-cycle button pulses and the direction switch.
- Generates the 1 Hz step strobes, hour/minute set strobes, clear and count direction that drive the datapath.
- Produces a per-digit blank mask for blinking, plus a done flag for countdown expiry.

Parameters:
CLK_DIV, 100000000, clk cycles per 1 Hz tick (≥4, even); bench uses 10

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn_start  in  1  start/stop pulse, one cycle, debounced upstream
btn_mode  in  1  mode pulse, one cycle
btn_inc  in  1  increment pulse, one cycle
dir_sw  in  1  level; 0 = count up, 1 = count down
cnt_zero  in  1  datapath reads 00:00:00 (combinational from digits)
sec_step  out  1  one-cycle strobe: step seconds digits in count_down direction
min_step  out  1  one-cycle strobe: increment minutes (set mode)
hour_step  out  1  one-cycle strobe: increment hours (set mode)
clear  out  1  one-cycle strobe: load 00:00:00
count_down  out  1  direction to datapath, latched
blank  out  6  per-digit blank mask, bit i blanks value_i
done  out  1  countdown expired
state  out  3  current state encoding, for debug/LEDs

Behaviour:
- Reset (async, rst=1):
  - state=IDLE(0), prescaler=0, count_down=0.
  - All strobes, blank and done = 0.
  - Release is synchronous to the next clk edge.
- States: IDLE=0, RUN=1, PAUSE=2, SET_HOUR=3, SET_MIN=4, DONE=5. Codes 6 and 7 are illegal and return to IDLE next cycle with all outputs 0.
- Button priority when pulses coincide: btn_start > btn_mode > btn_inc. Lower-priority pulses in the same cycle are dropped.
- All outputs are registered. A strobe asserts exactly one cycle, the cycle after its causing event. At most one of sec_step/min_step/hour_step/clear is high in any cycle.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps; tick = (prescaler == CLK_DIV-1).
  - Runs in all states except PAUSE, where it holds its value.
  - Forced to 0 on the IDLE->RUN transition.
  - blink_phase = (prescaler >= CLK_DIV/2).
- IDLE:
  - btn_start: latch count_down <= dir_sw. If dir_sw=1 and cnt_zero=1, stay IDLE (nothing to count). Otherwise go to RUN.
  - btn_mode: go to SET_HOUR.
  - btn_inc: ignored.
- RUN:
  - On tick: if count_down=1 and cnt_zero=1, go to DONE with no sec_step. Else pulse sec_step.
  - btn_start: go to PAUSE; a tick in the same cycle is suppressed.
  - btn_mode, btn_inc: ignored.
  - dir_sw changes are ignored in RUN and PAUSE.
- PAUSE:
  - btn_start: go to RUN, prescaler resumes from its held value.
  - btn_mode: pulse clear and go to IDLE.
- SET_HOUR:
  - btn_inc: pulse hour_step. Hour wrap 23->00 is the datapath's job.
  - btn_mode: go to SET_MIN.
  - btn_start: go to IDLE.
- SET_MIN:
  - btn_inc: pulse min_step.
  - btn_mode: go to IDLE.
  - btn_start: go to IDLE.
- DONE:
  - done=1.
  - Any button: pulse clear, go to IDLE, done=0 the same cycle clear is high.
- blank:
  - SET_HOUR: {2'b00, {2{blink_phase}}, 2'b00}.
  - SET_MIN: {4'b0000, {2{blink_phase}}}.
  - DONE: {6{blink_phase}}.
  - All other states: 6'b0.
- count_down holds its value outside IDLE and is updated only on an accepted btn_start in IDLE.
- Reset mid-operation (any state, strobe in flight): all outputs drop to 0 immediately (asynchronous), state=IDLE.

Test Plan:
1. Reset then release, btn_start with dir_sw=0 → state=RUN; with CLK_DIV=10, sec_step pulses every 10 cycles, first pulse 10 cycles after start; count_down=0, blank=0.
2. In RUN, btn_start → PAUSE, no sec_step while paused. btn_start again → first sec_step (CLK_DIV − held count) cycles later. In PAUSE, btn_mode → single clear pulse, state=IDLE.
3. From IDLE, btn_mode, 3×btn_inc, btn_mode, 2×btn_inc, btn_mode → exactly 3 hour_step then 2 min_step pulses, state back to IDLE. blank[3:2] toggles every 5 cycles in SET_HOUR; blank[1:0] toggles every 5 cycles in SET_MIN.
4. dir_sw=1, cnt_zero=1, btn_start → stays IDLE, no strobes. With cnt_zero=0, start, then raise cnt_zero → next tick enters DONE with no sec_step; done=1, blank=6'h3F/6'h00 alternating every 5 cycles; btn_inc → clear pulse, done=0, state=IDLE.
5. btn_start, btn_mode and btn_inc high in the same cycle in IDLE → RUN only, no set strobes. In SET_HOUR, btn_mode+btn_inc together → SET_MIN, no hour_step.
6. Assert rst during the cycle a sec_step is due → sec_step=0, state=0, blank=0 immediately. After release, the next start behaves as in scenario 1.
